output_arbiter: RTL and testbench

OUTPUT_ARBITER -- requirements
Module: output_arbiter

---
 rtl/output_arbiter_pkg.sv | 37 +++
 rtl/output_arbiter_rr_pick.sv | 33 +++
 rtl/output_arbiter.sv | 138 +++++++++++++
 tb/tb_output_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/output_arbiter_pkg.sv
// Shared port codes, FSM encodings and helpers for the router output-port arbiter.
// Crossbar select codes keep NO_PORT distinct from every port so the crossbar falls back to its idle default.
package output_arbiter_pkg;

   localparam int SEL_W     = 3;
   localparam int PKT_LEN_W = 8;

   localparam logic [SEL_W-1:0] NO_PORT = 3'b000;
   localparam logic [SEL_W-1:0] E_PORT  = 3'b001;
   localparam logic [SEL_W-1:0] S_PORT  = 3'b010;
   localparam logic [SEL_W-1:0] L_PORT  = 3'b100;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_E = 2'd1,
      GNT_S = 2'd2,
      GNT_L = 2'd3
   } arb_state_e;

   // Port index, also the round-robin pointer encoding (E -> S -> L -> E).
   typedef enum logic [1:0] {
      PID_E = 2'd0,
      PID_S = 2'd1,
      PID_L = 2'd2
   } port_id_e;

   function automatic arb_state_e gnt_state(input logic [1:0] port);
      arb_state_e st;
      case (port)
         PID_E:   st = GNT_E;
         PID_S:   st = GNT_S;
         default: st = GNT_L;
      endcase
      return st;
   endfunction

endpackage

// File: rtl/output_arbiter_rr_pick.sv
// Combinational 3-request round-robin picker: the winner is the first requester after 'last'.
module rr_pick
   import output_arbiter_pkg::*;
(
   input  logic [2:0] req,
   input  logic [1:0] last,
   output logic [1:0] winner,
   output logic       any
);

   always_comb begin
      winner = PID_E;
      any    = |req;
      case (last)
         PID_E: begin
            if (req[PID_S])      winner = PID_S;
            else if (req[PID_L]) winner = PID_L;
            else                 winner = PID_E;
         end
         PID_S: begin
            if (req[PID_L])      winner = PID_L;
            else if (req[PID_E]) winner = PID_E;
            else                 winner = PID_S;
         end
         default: begin
            if (req[PID_E])      winner = PID_E;
            else if (req[PID_S]) winner = PID_S;
            else                 winner = PID_L;
         end
      endcase
   end

endmodule

// File: rtl/output_arbiter.sv
// Output-port arbiter: round-robin among E/S/L input FIFOs, optional wormhole packet locking.
// ARB_PKT_LOCK_EN defined: a grant is held until the tail flit; undefined: every flit re-arbitrates.
//
//   state | meaning
//   IDLE  | no owner, sel_out = NO_PORT, waiting for any request
//   GNT_E | east FIFO owns the output, flits pop while E_req & ready_in
//   GNT_S | south FIFO owns the output
//   GNT_L | local FIFO owns the output
module output_arbiter
   import output_arbiter_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             E_req,
   input  logic             S_req,
   input  logic             L_req,
   input  logic             E_tail,
   input  logic             S_tail,
   input  logic             L_tail,
   input  logic             ready_in,
   output logic [SEL_W-1:0] sel_out,
   output logic             E_grant,
   output logic             S_grant,
   output logic             L_grant,
   output logic             valid_out
);

   arb_state_e           state;
   arb_state_e           state_nxt;
   logic [1:0]           last_gnt;
   logic [1:0]           last_gnt_nxt;
   logic [PKT_LEN_W-1:0] pkt_len;
   logic [PKT_LEN_W-1:0] pkt_len_nxt;

   logic [2:0] req_vec;
   logic [1:0] cur_port;
   logic       cur_req;
   logic       cur_tail;
   logic       xfer;
   logic       release_port;
   logic [1:0] pick_last;
   logic [1:0] winner;
   logic       any_req;

   assign req_vec = {L_req, S_req, E_req};

   // A tail hand-off arbitrates starting after the current owner, so it is eligible last.
   assign pick_last = (state == IDLE) ? last_gnt : cur_port;

   rr_pick u_rr_pick (
      .req    (req_vec),
      .last   (pick_last),
      .winner (winner),
      .any    (any_req)
   );

`ifdef ARB_PKT_LOCK_EN
   assign release_port = cur_tail;
`else
   logic unused_tail;
   assign unused_tail  = cur_tail;
   assign release_port = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         last_gnt <= PID_L;
         pkt_len  <= '0;
      end else begin
         state    <= state_nxt;
         last_gnt <= last_gnt_nxt;
         pkt_len  <= pkt_len_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      last_gnt_nxt = last_gnt;
      pkt_len_nxt  = pkt_len;
      if (state == IDLE) begin
         if (any_req) begin
            state_nxt   = gnt_state(winner);
            pkt_len_nxt = '0;
         end
      end else if (xfer) begin
         pkt_len_nxt = (pkt_len == {PKT_LEN_W{1'b1}}) ? pkt_len : pkt_len + 1'b1;
         if (release_port) begin
            last_gnt_nxt = cur_port;
            if (any_req) begin
               state_nxt   = gnt_state(winner);
               pkt_len_nxt = '0;
            end else begin
               state_nxt = IDLE;
            end
         end
      end
   end

   always_comb begin
      sel_out  = NO_PORT;
      cur_port = PID_E;
      cur_req  = 1'b0;
      cur_tail = 1'b0;
      case (state)
         GNT_E: begin
            sel_out  = E_PORT;
            cur_port = PID_E;
            cur_req  = E_req;
            cur_tail = E_tail;
         end
         GNT_S: begin
            sel_out  = S_PORT;
            cur_port = PID_S;
            cur_req  = S_req;
            cur_tail = S_tail;
         end
         GNT_L: begin
            sel_out  = L_PORT;
            cur_port = PID_L;
            cur_req  = L_req;
            cur_tail = L_tail;
         end
         default: begin
            sel_out  = NO_PORT;
            cur_port = PID_E;
            cur_req  = 1'b0;
            cur_tail = 1'b0;
         end
      endcase
      xfer      = (state != IDLE) && cur_req && ready_in;
      valid_out = xfer;
      E_grant   = xfer && (state == GNT_E);
      S_grant   = xfer && (state == GNT_S);
      L_grant   = xfer && (state == GNT_L);
   end

endmodule

// File: tb/tb_output_arbiter.sv
// Self-checking bench for output_arbiter: directed scenarios plus random traffic against a
// port-ownership reference model (owner index, round-robin pointer, per-packet flit count).
module tb_output_arbiter;
   import output_arbiter_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       E_req = 1'b0, S_req = 1'b0, L_req = 1'b0;
   logic       E_tail = 1'b0, S_tail = 1'b0, L_tail = 1'b0;
   logic       ready_in = 1'b0;
   logic [2:0] sel_out;
   logic       E_grant, S_grant, L_grant, valid_out;

   int errors = 0;
   int checks = 0;

   // Reference model: -1 = no owner, otherwise 0=E, 1=S, 2=L.
   int m_owner = -1;
   int m_last  = 2;
   int m_pkt   = 0;
   int m_xfer_port = -1;
   int sent[3];

   always #5 clk = ~clk;

   output_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .E_req     (E_req),
      .S_req     (S_req),
      .L_req     (L_req),
      .E_tail    (E_tail),
      .S_tail    (S_tail),
      .L_tail    (L_tail),
      .ready_in  (ready_in),
      .sel_out   (sel_out),
      .E_grant   (E_grant),
      .S_grant   (S_grant),
      .L_grant   (L_grant),
      .valid_out (valid_out)
   );

   function automatic int pick(input logic [2:0] r, input int last);
      for (int k = 1; k <= 3; k++) begin
         int p;
         p = (last + k) % 3;
         if (r[p]) return p;
      end
      return -1;
   endfunction

   function automatic logic [2:0] port_code(input int o);
      case (o)
         0:       return E_PORT;
         1:       return S_PORT;
         2:       return L_PORT;
         default: return NO_PORT;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit e, input bit s, input bit l,
                        input bit et, input bit st, input bit lt, input bit rdy);
      E_req = e;  S_req = s;  L_req = l;
      E_tail = et; S_tail = st; L_tail = lt;
      ready_in = rdy;
   endtask

   // Called just after a falling edge with inputs driven; checks outputs, then advances one cycle.
   task automatic step(input string tag);
      logic [2:0] rv, tv;
      bit xf, rel;
      int w;
      #1;
      rv = {L_req, S_req, E_req};
      tv = {L_tail, S_tail, E_tail};
      xf = (m_owner >= 0) && rv[m_owner] && ready_in;
      check({tag, ".sel"},   32'(sel_out), 32'(port_code(m_owner)));
      check({tag, ".grant"}, 32'({L_grant, S_grant, E_grant}), xf ? (32'd1 << m_owner) : 32'd0);
      check({tag, ".valid"}, 32'(valid_out), 32'(xf));
      if (m_owner >= 0) check({tag, ".pkt_len"}, 32'(dut.pkt_len), 32'(m_pkt));
      m_xfer_port = xf ? m_owner : -1;
      @(posedge clk);
      if (m_owner < 0) begin
         w = pick(rv, m_last);
         if (w >= 0) begin
            m_owner = w;
            m_pkt   = 0;
         end
      end else if (xf) begin
`ifdef ARB_PKT_LOCK_EN
         rel = tv[m_owner];
`else
         rel = 1'b1;
`endif
         if (m_pkt < 255) m_pkt++;
         if (rel) begin
            m_last = m_owner;
            w = pick(rv, m_owner);
            m_owner = w;
            if (w >= 0) m_pkt = 0;
         end
      end
      @(negedge clk);
   endtask

   // Asserts reset partway into the low phase so it lands mid-cycle.
   task automatic do_reset(input string tag);
      #2 rst = 1'b0;
      #1;
      check({tag, ".rst_sel"},   32'(sel_out), 32'(NO_PORT));
      check({tag, ".rst_grant"}, 32'({L_grant, S_grant, E_grant}), 32'd0);
      check({tag, ".rst_valid"}, 32'(valid_out), 32'd0);
      check({tag, ".rst_pkt"},   32'(dut.pkt_len), 32'd0);
      m_owner = -1;
      m_last  = 2;
      m_pkt   = 0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      @(negedge clk);
      do_reset("init");

      // All ports request single-flit packets: NO_PORT, E, S, L, E.
      drive(1, 1, 1, 1, 1, 1, 1);
      for (int i = 0; i < 5; i++) step("rr_all");

      // S 4-flit packet with E waiting.
      do_reset("s_pkt");
      drive(0, 1, 0, 0, 0, 0, 1);
      step("s_pkt.idle");
      for (int i = 0; i < 4; i++) begin
         drive(1, 1, 0, 0, (i == 3), 0, 1);
         step("s_pkt.body");
      end
      drive(1, 0, 0, 1, 0, 0, 1);
      step("s_pkt.e_next");
      drive(0, 0, 0, 0, 0, 0, 1);
      step("s_pkt.drain");

      // L stalls mid-packet with E requesting.
      do_reset("l_stall");
      drive(0, 0, 1, 0, 0, 0, 1);
      step("l_stall.idle");
      for (int i = 0; i < 2; i++) step("l_stall.flit");
      drive(1, 0, 0, 1, 0, 0, 1);
      for (int i = 0; i < 3; i++) step("l_stall.empty");
      drive(1, 0, 1, 1, 0, 1, 1);
      step("l_stall.resume");
      step("l_stall.after");

      // Backpressure during GNT_E.
      do_reset("bp");
      drive(1, 0, 0, 0, 0, 0, 1);
      step("bp.idle");
      step("bp.flit1");
      drive(1, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) step("bp.stall");
      drive(1, 1, 0, 1, 0, 0, 1);
      step("bp.resume");
      step("bp.after");

      // Reset during flit 2, then E wins first.
      drive(0, 1, 0, 0, 0, 0, 1);
      step("mid.idle");
      step("mid.flit1");
      do_reset("mid");
      drive(1, 1, 1, 0, 0, 0, 1);
      step("mid.post_idle");
      step("mid.post_first");

      // E and S 3-flit packets concurrently.
      do_reset("conc");
      sent = '{0, 0, 0};
      for (int i = 0; i < 8; i++) begin
         drive(sent[0] < 3, sent[1] < 3, 0, sent[0] == 2, sent[1] == 2, 0, 1);
         step("conc");
         if (m_xfer_port >= 0) sent[m_xfer_port]++;
      end

      // Long E stream to reach pkt_len saturation under packet locking.
      do_reset("sat");
      drive(1, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 262; i++) step("sat");

      // Random traffic.
      do_reset("rnd");
      for (int i = 0; i < 600; i++) begin
         drive($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6,
               $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
               $urandom_range(0, 3) != 0);
         step("rnd");
         if ($urandom_range(0, 199) == 0) do_reset("rnd");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
